fitness_eval: RTL

FITNESS_EVAL -- requirements
Module: fitness_eval

---
 rtl/gaa_fitness_pkg.sv | 33 +++
 rtl/fitness_accum.sv | 51 +++++
 rtl/fitness_eval.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gaa_fitness_pkg.sv
// gaa_fitness_pkg: shared constants for the knapsack fitness evaluator.
// Holds the Avalon-MM register map, CTRL/STATUS bit positions and the FSM state type.
// No ports; imported by fitness_eval.
package gaa_fitness_pkg;

   // Single-register word addresses
   localparam logic [6:0] ADDR_CTRL     = 7'h00;
   localparam logic [6:0] ADDR_STATUS   = 7'h01;
   localparam logic [6:0] ADDR_CAPACITY = 7'h02;
   localparam logic [6:0] ADDR_FITNESS  = 7'h03;
   localparam logic [6:0] ADDR_CHROM    = 7'h04;

   // Per-item banks: address[6:5] selects the bank, address[4:0] the item
   localparam logic [1:0] BANK_WEIGHT   = 2'b01;   // 0x20 + i
   localparam logic [1:0] BANK_VALUE    = 2'b10;   // 0x40 + i

   // CTRL bits (write side)
   localparam int CTRL_START    = 0;
   localparam int CTRL_CLR_DONE = 1;
   localparam int CTRL_IRQ_EN   = 2;

   // STATUS bits (read side)
   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_OVW      = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/fitness_accum.sv
// fitness_accum: conditional weight/value accumulation and capacity check.
// Ports: clk/rst; clr zeroes both sums; en+sel adds weight/value this cycle;
//        value_sum and fits (weight sum <= capacity) reflect the registered sums.
module fitness_accum #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              sel,
   input  logic [DATA_W-1:0] weight,
   input  logic [DATA_W-1:0] value,
   input  logic [DATA_W-1:0] capacity,
   output logic [DATA_W+4:0] value_sum,
   output logic              fits
);

   // Five guard bits cover up to 32 items of full-scale weight or value.
   localparam int ACC_W = DATA_W + 5;

   logic [ACC_W-1:0] wsum_d, wsum_q;
   logic [ACC_W-1:0] vsum_d, vsum_q;

   always_comb begin
      wsum_d = wsum_q;
      vsum_d = vsum_q;
      if (clr) begin
         wsum_d = '0;
         vsum_d = '0;
      end else if (en && sel) begin
         wsum_d = wsum_q + ACC_W'(weight);
         vsum_d = vsum_q + ACC_W'(value);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wsum_q <= '0;
         vsum_q <= '0;
      end else begin
         wsum_q <= wsum_d;
         vsum_q <= vsum_d;
      end
   end

   assign value_sum = vsum_q;
   // Equal to capacity still counts as fitting.
   assign fits      = (wsum_q <= ACC_W'(capacity));

endmodule

// File: rtl/fitness_eval.sv
// fitness_eval: Avalon-MM register bank + FSM scoring one knapsack chromosome (one item per cycle).
// Ports: clk, reset (async high), chipselect/write/read/address/writedata, registered readdata;
//        irq (done AND irq enable, registered) exists only when FITNESS_IRQ_EN is defined.
module fitness_eval
   import gaa_fitness_pkg::*;
#(
   parameter int N_ITEMS = 16,
   parameter int DATA_W  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [6:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
`ifdef FITNESS_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
   localparam int ACC_W = DATA_W + 5;

   state_t              state_d, state_q;
   logic [IDX_W-1:0]    idx_d, idx_q;
   logic [DATA_W-1:0]   capacity_d, capacity_q;
   logic [N_ITEMS-1:0]  chrom_d, chrom_q;
   logic [DATA_W-1:0]   weight_d [N_ITEMS];
   logic [DATA_W-1:0]   weight_q [N_ITEMS];
   logic [DATA_W-1:0]   value_d  [N_ITEMS];
   logic [DATA_W-1:0]   value_q  [N_ITEMS];
   logic [ACC_W-1:0]    fitness_d, fitness_q;
   logic                done_d, done_q;
   logic                ovw_d, ovw_q;
   logic [31:0]         readdata_d, readdata_q;
`ifdef FITNESS_IRQ_EN
   logic                irq_en_d, irq_en_q;
   logic                irq_d, irq_q;
`endif

   logic                wr_en, rd_en, wr_ctrl, start, busy, last_item;
   logic                acc_clr, acc_en, finish;
   logic [DATA_W-1:0]   cur_w, cur_v;
   logic                cur_sel;
   logic [ACC_W-1:0]    value_sum;
   logic                fits;
   logic                unused_wdata;

   // Upper writedata bits are intentionally dropped for narrow registers.
   assign unused_wdata = ^writedata;

   assign wr_en     = chipselect && write;
   assign rd_en     = chipselect && read;
   assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
   assign busy      = (state_q != ST_IDLE);
   assign start     = wr_ctrl && writedata[CTRL_START] && (state_q == ST_IDLE);
   assign last_item = (idx_q == IDX_W'(N_ITEMS - 1));

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_RUN;
         ST_RUN:    if (last_item) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      acc_clr = start;
      acc_en  = (state_q == ST_RUN);
      finish  = (state_q == ST_FINISH);
   end

   // Item currently being scored
   always_comb begin
      cur_w   = '0;
      cur_v   = '0;
      cur_sel = 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_w   = weight_q[i];
            cur_v   = value_q[i];
            cur_sel = chrom_q[i];
         end
      end
   end

   fitness_accum #(.DATA_W(DATA_W)) u_accum (
      .clk       (clk),
      .rst       (reset),
      .clr       (acc_clr),
      .en        (acc_en),
      .sel       (cur_sel),
      .weight    (cur_w),
      .value     (cur_v),
      .capacity  (capacity_q),
      .value_sum (value_sum),
      .fits      (fits)
   );

   // ---------------- Register bank / datapath ----------------
   always_comb begin
      idx_d      = idx_q;
      capacity_d = capacity_q;
      chrom_d    = chrom_q;
      weight_d   = weight_q;
      value_d    = value_q;
      fitness_d  = fitness_q;
      done_d     = done_q;
      ovw_d      = ovw_q;

      if (start) begin
         idx_d  = '0;
         done_d = 1'b0;
         ovw_d  = 1'b0;
      end else if (state_q == ST_RUN) begin
         idx_d  = idx_q + 1'b1;
      end

      if (wr_ctrl && writedata[CTRL_CLR_DONE]) done_d = 1'b0;

      // A completing run wins over a clear landing in the same cycle.
      if (finish) begin
         fitness_d = fits ? value_sum : '0;
         ovw_d     = !fits;
         done_d    = 1'b1;
      end

      // Configuration is frozen while a run is scoring it.
      if (wr_en && !busy) begin
         if (address == ADDR_CAPACITY) capacity_d = writedata[DATA_W-1:0];
         if (address == ADDR_CHROM)    chrom_d    = writedata[N_ITEMS-1:0];
         for (int i = 0; i < N_ITEMS; i++) begin
            if (address[4:0] == 5'(i)) begin
               if (address[6:5] == BANK_WEIGHT) weight_d[i] = writedata[DATA_W-1:0];
               if (address[6:5] == BANK_VALUE)  value_d[i]  = writedata[DATA_W-1:0];
            end
         end
      end
   end

`ifdef FITNESS_IRQ_EN
   always_comb begin
      irq_en_d = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;
      // Built from next-state values so irq tracks done on the same edge.
      irq_d    = done_d && irq_en_d;
   end
   assign irq = irq_q;
`endif

   // Read mux; readdata holds between reads.
   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         readdata_d = '0;
         case (address)
            ADDR_STATUS:   begin
               readdata_d[STAT_BUSY] = busy;
               readdata_d[STAT_DONE] = done_q;
               readdata_d[STAT_OVW]  = ovw_q;
            end
            ADDR_CAPACITY: readdata_d = 32'(capacity_q);
            ADDR_FITNESS:  readdata_d = 32'(fitness_q);
            ADDR_CHROM:    readdata_d = 32'(chrom_q);
            default: begin
               for (int i = 0; i < N_ITEMS; i++) begin
                  if (address[4:0] == 5'(i)) begin
                     if (address[6:5] == BANK_WEIGHT) readdata_d = 32'(weight_q[i]);
                     if (address[6:5] == BANK_VALUE)  readdata_d = 32'(value_q[i]);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         capacity_q <= '0;
         chrom_q    <= '0;
         for (int i = 0; i < N_ITEMS; i++) begin
            weight_q[i] <= '0;
            value_q[i]  <= '0;
         end
         fitness_q  <= '0;
         done_q     <= 1'b0;
         ovw_q      <= 1'b0;
         readdata_q <= '0;
`ifdef FITNESS_IRQ_EN
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         capacity_q <= capacity_d;
         chrom_q    <= chrom_d;
         weight_q   <= weight_d;
         value_q    <= value_d;
         fitness_q  <= fitness_d;
         done_q     <= done_d;
         ovw_q      <= ovw_d;
         readdata_q <= readdata_d;
`ifdef FITNESS_IRQ_EN
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
`endif
      end
   end

   assign readdata = readdata_q;

endmodule
